// File: rtl/pc_fetch_unit_if.sv
// Purpose: handshake/bus bundle between the PC fetch unit, the branch mux,
//          instruction memory and decode.
// Signals:
//   pcNext      next PC from the branch mux
//   stall       decode/hazard stall (1 = hold current instruction)
//   add4Out     pcOut + 4, back to the branch mux
//   pcOut       current PC
//   imemReq     fetch request to instruction memory
//   imemAddr    fetch address (equals pcOut)
//   imemAck     memory returns imemRdata this cycle
//   imemRdata   fetched instruction word
//   instrOut    registered instruction to decode
//   instrValid  instrOut holds a valid instruction
//   misalignErr sticky misalignment flag
// Modports: master = fetch unit side, slave = environment side.
interface pc_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic [ADDR_W-1:0] pcNext;
    logic              stall;
    logic [ADDR_W-1:0] add4Out;
    logic [ADDR_W-1:0] pcOut;
    logic              imemReq;
    logic [ADDR_W-1:0] imemAddr;
    logic              imemAck;
    logic [31:0]       imemRdata;
    logic [31:0]       instrOut;
    logic              instrValid;
    logic              misalignErr;

    modport master (
        input  pcNext, stall, imemAck, imemRdata,
        output add4Out, pcOut, imemReq, imemAddr, instrOut, instrValid, misalignErr
    );

    modport slave (
        output pcNext, stall, imemAck, imemRdata,
        input  add4Out, pcOut, imemReq, imemAddr, instrOut, instrValid, misalignErr
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Purpose: program-counter register and instruction-fetch sequencer.
//          Fetches the word at pcOut over a req/ack handshake, presents it to
//          decode with a valid/stall handshake, then loads pcNext.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pc_fetch_unit_if.master (branch mux, imem and decode signals)
// Optional feature: define MISALIGN_TRAP_EN to trap on a misaligned pcNext
//   (sticky misalignErr, fetch halted until reset). Undefined: misalignErr=0
//   and pcNext is loaded unchanged.
module pc_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_fetch_unit_if.master bus
);

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_pc, w_pc_nxt;
    logic [INSTR_W-1:0]  r_instr, w_instr_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_req, w_req_nxt;
    logic                r_err, w_err_nxt;
    logic                w_misalign;

    // Misalignment detection only exists with the trap feature built in.
`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (bus.pcNext[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    // Next-state and next-register values.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err;

        unique case (r_state)
            ST_BOOT: begin
                // A trapped unit parks in BOOT until reset.
                if (!r_err) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.imemAck) begin
                    w_instr_nxt = bus.imemRdata;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.stall) begin
                    w_valid_nxt = 1'b0;
                    if (w_misalign) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_BOOT;
                    end else begin
                        w_pc_nxt    = bus.pcNext;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_valid_nxt = 1'b0;
            end
        endcase

        // Request is registered and asserted for exactly the FETCH cycles.
        w_req_nxt = (w_state_nxt == ST_FETCH);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_req   <= w_req_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.pcOut       = r_pc;
    assign bus.add4Out     = r_pc + ADDR_W'(4);
    assign bus.imemAddr    = r_pc;
    assign bus.imemReq     = r_req;
    assign bus.instrOut    = r_instr;
    assign bus.instrValid  = r_valid;
    assign bus.misalignErr = r_err;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Purpose: self-checking bench for pc_fetch_unit. A driver acts as branch mux,
//          instruction memory and decode; each memory response is pushed into
//          a scoreboard and a monitor pops it when decode sees instrValid rise.
module tb_pc_fetch_unit;

    localparam int unsigned ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    pc_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Directed scripts; empty queues fall back to random choices.
    int          delay_q[$];
    int          stall_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] rdata_q[$];

    // Reference model state: architectural PC, trap flag, handshake bookkeeping.
    logic [31:0] mdl_pc      = RESET_PC;
    bit          mdl_trapped = 1'b0;
    bit          have_exp    = 1'b0;
    bit          exp_req     = 1'b0;
    bit          exp_valid   = 1'b0;
    bit          in_fetch    = 1'b0;
    bit          in_issue    = 1'b0;
    int          wait_cnt    = 0;
    int          ack_delay   = 0;
    int          stall_cnt   = 0;
    int          stall_len   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick_delay();
        if (delay_q.size() != 0) return delay_q.pop_front();
        return ($urandom_range(1) == 0) ? 0 : int'($urandom_range(4, 1));
    endfunction

    function automatic int pick_stall();
        if (stall_q.size() != 0) return stall_q.pop_front();
        return ($urandom_range(1) == 0) ? 0 : int'($urandom_range(4, 1));
    endfunction

    function automatic logic [31:0] pick_pc();
        if (pc_q.size() != 0) return pc_q.pop_front();
        if ($urandom_range(1) == 0) return mdl_pc + 32'd4;
        return $urandom() & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] pick_rdata();
        if (rdata_q.size() != 0) return rdata_q.pop_front();
        return $urandom();
    endfunction

    task automatic model_reset();
        mdl_pc      = RESET_PC;
        mdl_trapped = 1'b0;
        in_fetch    = 1'b0;
        in_issue    = 1'b0;
        wait_cnt    = 0;
        stall_cnt   = 0;
        // First cycle after release is the idle BOOT cycle.
        have_exp    = 1'b1;
        exp_req     = 1'b0;
        exp_valid   = 1'b0;
    endtask

    // One driver cycle per negedge: check last cycle's expectation, then drive.
    task automatic run_cycles(input int n);
        logic        s_req, s_valid;
        logic [31:0] nxt, rd;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            s_req   = bus.imemReq;
            s_valid = bus.instrValid;
            if (have_exp) begin
                check("imemReq", 32'(s_req), 32'(exp_req));
                check("instrValid", 32'(s_valid), 32'(exp_valid));
            end
            check("pcOut", bus.pcOut, mdl_pc);
            check("imemAddr", bus.imemAddr, mdl_pc);
            check("add4Out", bus.add4Out, mdl_pc + 32'd4);
            check("misalignErr", 32'(bus.misalignErr), 32'(mdl_trapped));

            // Background noise: stall ignored in FETCH, pcNext ignored off-issue.
            bus.imemAck   = 1'b0;
            bus.imemRdata = $urandom();
            bus.stall     = 1'($urandom_range(1));
            bus.pcNext    = $urandom();
            have_exp      = 1'b1;

            if (s_req) begin
                if (!in_fetch) begin
                    in_fetch  = 1'b1;
                    wait_cnt  = 0;
                    ack_delay = pick_delay();
                end
                if (wait_cnt >= ack_delay) begin
                    rd            = pick_rdata();
                    bus.imemAck   = 1'b1;
                    bus.imemRdata = rd;
                    exp_q.push_back('{pc: mdl_pc, instr: rd});
                    in_fetch  = 1'b0;
                    exp_req   = 1'b0;
                    exp_valid = 1'b1;
                end else begin
                    wait_cnt++;
                    exp_req   = 1'b1;
                    exp_valid = 1'b0;
                end
            end else if (s_valid) begin
                if (!in_issue) begin
                    in_issue  = 1'b1;
                    stall_cnt = 0;
                    stall_len = pick_stall();
                end
                // Spurious ack during issue must not disturb instrOut.
                bus.imemAck = 1'($urandom_range(1));
                if (stall_cnt < stall_len) begin
                    bus.stall = 1'b1;
                    stall_cnt++;
                    exp_req   = 1'b0;
                    exp_valid = 1'b1;
                end else begin
                    nxt        = pick_pc();
                    bus.stall  = 1'b0;
                    bus.pcNext = nxt;
                    in_issue   = 1'b0;
                    exp_valid  = 1'b0;
                    if (TRAP && nxt[1:0] != 2'b00) begin
                        mdl_trapped = 1'b1;
                        exp_req     = 1'b0;
                    end else begin
                        mdl_pc  = nxt;
                        exp_req = 1'b1;
                    end
                end
            end else begin
                exp_valid = 1'b0;
                exp_req   = !mdl_trapped;
            end
        end
    endtask

    // Scoreboard monitor: pop on each new instruction, then check it is held.
    initial begin
        exp_t cur;
        bit   prev_valid;
        cur        = '0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                prev_valid = 1'b0;
            end else begin
                if (bus.instrValid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_empty: instrValid rose with no fetch outstanding, instrOut=%h", bus.instrOut);
                    end else begin
                        cur = exp_q.pop_front();
                        check("sb_instr", bus.instrOut, cur.instr);
                        check("sb_pc", bus.pcOut, cur.pc);
                    end
                end else if (bus.instrValid) begin
                    check("hold_instr", bus.instrOut, cur.instr);
                    check("hold_pc", bus.pcOut, cur.pc);
                end
                prev_valid = bus.instrValid;
            end
        end
    end

    initial begin
        bit found;
        bus.pcNext    = '0;
        bus.stall     = 1'b0;
        bus.imemAck   = 1'b0;
        bus.imemRdata = '0;

        // Reset values.
        @(posedge clk);
        #1;
        check("rst_pcOut", bus.pcOut, RESET_PC);
        check("rst_instrOut", bus.instrOut, 32'h0);
        check("rst_instrValid", 32'(bus.instrValid), 32'h0);
        check("rst_imemReq", 32'(bus.imemReq), 32'h0);
        check("rst_misalignErr", 32'(bus.misalignErr), 32'h0);
        check("rst_add4Out", bus.add4Out, 32'h0040_0004);

        // Zero-wait memory, no stall, sequential PC.
        delay_q = '{0, 0, 0};
        stall_q = '{0, 0, 0};
        pc_q    = '{32'h0040_0004, 32'h0040_0008, 32'h0040_000C};
        rdata_q = '{32'h2008_0005, 32'h2008_0005, 32'h2008_0005};
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        run_cycles(7);

        // Ack delayed by 3 cycles, short stall with spurious acks.
        delay_q = '{3, 3};
        stall_q = '{2, 0};
        run_cycles(14);

        // Taken branch held by a 4-cycle stall.
        delay_q = '{0, 0};
        stall_q = '{4, 0};
        pc_q    = '{32'h0040_0040, 32'h0040_0044};
        run_cycles(12);

        // PC at the top of the address space: add4Out wraps to zero.
        stall_q = '{0, 1, 0};
        pc_q    = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0040_0100};
        run_cycles(14);

        // Randomized traffic.
        run_cycles(400);

        // Reset while a long fetch is outstanding.
        delay_q.delete();
        stall_q.delete();
        pc_q.delete();
        delay_q.push_back(30);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            run_cycles(1);
            found = in_fetch && (wait_cnt >= 2);
        end
        check("midfetch_reached", 32'(found), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_imemReq", 32'(bus.imemReq), 32'h0);
        check("async_rst_instrValid", 32'(bus.instrValid), 32'h0);
        check("async_rst_pcOut", bus.pcOut, RESET_PC);
        bus.imemAck   = 1'b1;
        bus.imemRdata = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #2;
        check("rst_ack_instrOut", bus.instrOut, 32'h0);
        check("rst_ack_instrValid", 32'(bus.instrValid), 32'h0);
        bus.imemAck = 1'b0;
        delay_q.delete();
        rst_n = 1'b1;
        model_reset();
        run_cycles(20);

        // Misaligned pcNext at issue.
        stall_q = '{0};
        pc_q    = '{32'h0040_0006};
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            run_cycles(1);
            found = (pc_q.size() == 0);
        end
        check("misalign_issued", 32'(found), 32'h1);
        run_cycles(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter register and instruction-fetch sequencer. It sits directly downstream of the branch mux: it consumes the selected next-PC (muxBranchOutp) and produces add4Out, which feeds back into the branch mux. It issues word fetches to instruction memory over a req/ack handshake and presents each fetched instruction to decode with a valid/stall handshake.

Parameters:
ADDR_W, 32, PC and instruction-memory address width in bits
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
pcNext  input  ADDR_W  next PC from the branch mux (muxBranchOutp)
stall  input  1  decode/hazard stall; 1 = hold the current instruction
add4Out  output  ADDR_W  pcOut + 4, to the branch mux
pcOut  output  ADDR_W  current PC (registered)
imemReq  output  1  fetch request to instruction memory
imemAddr  output  ADDR_W  fetch address; always equals pcOut
imemAck  input  1  memory has returned imemRdata this cycle
imemRdata  input  32  fetched instruction word
instrOut  output  32  registered instruction to decode
instrValid  output  1  instrOut holds a valid instruction
misalignErr  output  1  sticky misalignment flag (only with MISALIGN_TRAP_EN; otherwise tied to 0)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pcOut=RESET_PC, instrOut=0, instrValid=0, imemReq=0, misalignErr=0.
  - FSM goes to BOOT.
  - Reset takes effect at any point, including mid-fetch; an outstanding request is abandoned and a late imemAck is ignored.
- add4Out = pcOut + 4, combinational, modulo 2^ADDR_W. 0xFFFFFFFC wraps to 0x00000000.
- imemAddr = pcOut, combinational.
- FSM states: BOOT, FETCH, ISSUE.
  - BOOT: imemReq=0, instrValid=0. Moves unconditionally to FETCH on the next edge. This gives one idle cycle after reset release.
  - FETCH:
    - imemReq=1 and imemAddr stays stable until imemAck.
    - On an edge where imemAck=1: instrOut<=imemRdata, instrValid<=1, go to ISSUE.
    - imemAck is allowed in the same cycle imemReq first rises.
    - stall is ignored in FETCH; a request is never withdrawn.
  - ISSUE:
    - imemReq=0, instrValid=1, and instrOut is held stable.
    - If stall=0: pcOut<=pcNext, instrValid<=0, go to FETCH.
    - If stall=1: pcOut, instrOut and instrValid hold, for any number of cycles.
    - imemAck in ISSUE is ignored.
- Throughput: with a zero-wait memory, one instruction every 2 cycles (FETCH, ISSUE).
- pcNext is sampled only on the ISSUE->FETCH edge. Changes at other times have no effect.
- Transition order is fixed: BOOT->FETCH->ISSUE->FETCH...; no other transitions.

Optional Feature:
Macro: MISALIGN_TRAP_EN
- Defined:
  - On the ISSUE->FETCH edge, if pcNext[1:0]!=0, pcOut is not updated, misalignErr<=1 (sticky until reset), and the FSM goes to BOOT and stays there.
  - From then on imemReq stays 0 and instrValid stays 0 until reset.
- Undefined:
  - pcNext is loaded unchanged, including its low bits.
  - misalignErr is driven constant 0.

Test Plan:
- Reset with RESET_PC=0x00400000, release rst_n -> one cycle of imemReq=0, then imemReq=1 with imemAddr=0x00400000; add4Out=0x00400004.
- Zero-wait memory (ack in the same cycle as req), stall=0, pcNext=add4Out, rdata 0x20080005 -> instrValid high every other cycle, instrOut=0x20080005; pcOut steps 0x00400000, 0x00400004, 0x00400008 at a 2-cycle period.
- imemAck delayed 3 cycles -> imemReq stays 1 and imemAddr stays stable for 4 cycles; instrValid rises only on the cycle after ack; a spurious ack during ISSUE does not change instrOut.
- stall=1 for 4 cycles in ISSUE, pcNext=0x00400040 (taken branch) -> instrValid=1, instrOut and pcOut unchanged throughout; on release, pcOut=0x00400040 and the next imemAddr=0x00400040.
- Pull rst_n low while imemReq=1 -> imemReq=0, instrValid=0, pcOut=RESET_PC immediately, without waiting for an edge; an ack arriving during reset has no effect.
- Force pcOut=0xFFFFFFFC -> add4Out=0x00000000. With MISALIGN_TRAP_EN, pcNext=0x00400006 at issue -> misalignErr=1, pcOut unchanged, imemReq stays 0.
